// File: rtl/xcel_sum_unit_pkg.sv
// xcel_sum_unit_pkg: message types, xr addresses and FSM states shared by the sum accelerator
package xcel_sum_unit_pkg;
  localparam logic VC_XCEL_REQ_MSG_TYPE_READ = 1'b0;
  localparam logic VC_XCEL_REQ_MSG_TYPE_WRITE = 1'b1;
  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ = 3'd0;
  localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_READ = 3'd0;
  localparam logic [4:0] XR_GO = 5'd0;
  localparam logic [4:0] XR_BASE = 5'd1;
  localparam logic [4:0] XR_SIZE = 5'd2;
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;
  typedef struct packed {
    logic [7:0] opaque;
    logic type_;
    logic [4:0] addr;
    logic [31:0] data;
  } xcel_req_t;
  typedef struct packed {
    logic [7:0] opaque;
    logic type_;
    logic [31:0] data;
  } xcel_resp_t;
  typedef struct packed {
    logic [2:0] type_;
    logic [7:0] opaque;
    logic [31:0] addr;
    logic [1:0] len;
    logic [31:0] data;
  } mem_req_4B_t;
  typedef struct packed {
    logic [2:0] type_;
    logic [7:0] opaque;
    logic [1:0] test;
    logic [1:0] len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

// File: rtl/xcel_sum_unit_mem_issuer.sv
// xcel_sum_unit_mem_issuer: windowed word-read issue with in-order response accumulation
module xcel_sum_unit_mem_issuer
  import xcel_sum_unit_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         active,
  input  logic [31:0]  base,
  input  logic [31:0]  size,
  output mem_req_4B_t  mem_req_msg,
  output logic         mem_req_val,
  input  logic         mem_req_rdy,
  input  mem_resp_4B_t mem_resp_msg,
  input  logic         mem_resp_val,
  output logic         mem_resp_rdy,
  output logic         done,
  output logic [31:0]  sum
);
  localparam int OW = $clog2(p_max_outstanding) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(p_max_outstanding);
  logic [31:0] issued_q, issued_d, recvd_q, recvd_d, acc_q, acc_d;
  logic [OW-1:0] outstanding;
  logic req_go, resp_go, unused_ok;
  assign unused_ok = ^{mem_resp_msg.type_, mem_resp_msg.opaque, mem_resp_msg.test, mem_resp_msg.len};
  always_comb begin
    outstanding = OW'(issued_q - recvd_q);
    mem_req_val = active && issued_q < size && outstanding < MAX_OUT;
    mem_resp_rdy = active;
    req_go = mem_req_val && mem_req_rdy;
    resp_go = mem_resp_val && mem_resp_rdy;
    issued_d = start ? '0 : issued_q + 32'(req_go);
    recvd_d = start ? '0 : recvd_q + 32'(resp_go);
    acc_d = start ? '0 : resp_go ? acc_q + mem_resp_msg.data : acc_q;
    done = active && recvd_d == size;
    sum = acc_d;
    mem_req_msg = mem_req_val ? mem_req_4B_t'{type_: VC_MEM_REQ_MSG_TYPE_READ, opaque: 8'd0,
                  addr: base + {issued_q[29:0], 2'b00}, len: 2'd0, data: 32'd0} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      recvd_q <= '0;
      acc_q <= '0;
    end else begin
      issued_q <= issued_d;
      recvd_q <= recvd_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/xcel_sum_unit.sv
// xcel_sum_unit: xcel responder that sums xr2 memory words from address xr1 into xr0
module xcel_sum_unit
  import xcel_sum_unit_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  xcel_req_t    xcel_reqstream_msg,
  input  logic         xcel_reqstream_val,
  output logic         xcel_reqstream_rdy,
  output xcel_resp_t   xcel_respstream_msg,
  output logic         xcel_respstream_val,
  input  logic         xcel_respstream_rdy,
  output mem_req_4B_t  mem_reqstream_msg,
  output logic         mem_reqstream_val,
  input  logic         mem_reqstream_rdy,
  input  mem_resp_4B_t mem_respstream_msg,
  input  logic         mem_respstream_val,
  output logic         mem_respstream_rdy
);
  state_e state_q, state_d;
  logic [31:0] xr0_q, xr0_d, xr1_q, xr1_d, xr2_q, xr2_d, rd_data, sum;
  logic resp_full_q, resp_full_d, req_go, wr, start, done;
  logic [4:0] a;
  xcel_resp_t resp_q, resp_d;
  xcel_sum_unit_mem_issuer #(.p_max_outstanding(p_max_outstanding)) issuer (
    .clk(clk),
    .reset(reset),
    .start(start),
    .active(state_q == CALC),
    .base(xr1_q),
    .size(xr2_q),
    .mem_req_msg(mem_reqstream_msg),
    .mem_req_val(mem_reqstream_val),
    .mem_req_rdy(mem_reqstream_rdy),
    .mem_resp_msg(mem_respstream_msg),
    .mem_resp_val(mem_respstream_val),
    .mem_resp_rdy(mem_respstream_rdy),
    .done(done),
    .sum(sum)
  );
  assign xcel_reqstream_rdy = state_q == IDLE && (!resp_full_q || xcel_respstream_rdy);
  assign xcel_respstream_val = resp_full_q;
  assign xcel_respstream_msg = resp_full_q ? resp_q : '0;
  always_comb begin
    req_go = xcel_reqstream_val && xcel_reqstream_rdy;
    wr = xcel_reqstream_msg.type_ == VC_XCEL_REQ_MSG_TYPE_WRITE;
    a = xcel_reqstream_msg.addr;
    start = req_go && wr && a == XR_GO;
    rd_data = a == XR_GO ? xr0_q : a == XR_BASE ? xr1_q : a == XR_SIZE ? xr2_q : '0;
    state_d = start ? CALC : done ? IDLE : state_q;
    xr0_d = done ? sum : xr0_q;
    xr1_d = req_go && wr && a == XR_BASE ? xcel_reqstream_msg.data : xr1_q;
    xr2_d = req_go && wr && a == XR_SIZE ? xcel_reqstream_msg.data : xr2_q;
    resp_full_d = req_go || (resp_full_q && !xcel_respstream_rdy);
    resp_d = req_go ? xcel_resp_t'{opaque: xcel_reqstream_msg.opaque, type_: xcel_reqstream_msg.type_,
             data: wr ? 32'd0 : rd_data} : resp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xr0_q <= '0;
      xr1_q <= '0;
      xr2_q <= '0;
      resp_full_q <= 1'b0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      xr0_q <= xr0_d;
      xr1_q <= xr1_d;
      xr2_q <= xr2_d;
      resp_full_q <= resp_full_d;
      resp_q <= resp_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && state_q == IDLE) assert (!mem_respstream_val);
endmodule

// File: tb/tb_xcel_sum_unit.sv
// tb_xcel_sum_unit: scoreboard bench for xcel_sum_unit with a delaying memory model
module tb_xcel_sum_unit;
  import xcel_sum_unit_pkg::*;
  localparam int P = 4;
  logic clk = 1'b0, reset = 1'b1;
  xcel_req_t xcel_reqstream_msg;
  logic xcel_reqstream_val, xcel_reqstream_rdy;
  xcel_resp_t xcel_respstream_msg;
  logic xcel_respstream_val, xcel_respstream_rdy;
  mem_req_4B_t mem_reqstream_msg;
  logic mem_reqstream_val, mem_reqstream_rdy;
  mem_resp_4B_t mem_respstream_msg;
  logic mem_respstream_val, mem_respstream_rdy;
  xcel_sum_unit #(.p_max_outstanding(P)) dut (
    .clk(clk),
    .reset(reset),
    .xcel_reqstream_msg(xcel_reqstream_msg),
    .xcel_reqstream_val(xcel_reqstream_val),
    .xcel_reqstream_rdy(xcel_reqstream_rdy),
    .xcel_respstream_msg(xcel_respstream_msg),
    .xcel_respstream_val(xcel_respstream_val),
    .xcel_respstream_rdy(xcel_respstream_rdy),
    .mem_reqstream_msg(mem_reqstream_msg),
    .mem_reqstream_val(mem_reqstream_val),
    .mem_reqstream_rdy(mem_reqstream_rdy),
    .mem_respstream_msg(mem_respstream_msg),
    .mem_respstream_val(mem_respstream_val),
    .mem_respstream_rdy(mem_respstream_rdy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] data;
    int due;
  } pend_t;
  pend_t pend_q[$];
  xcel_resp_t exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mem[logic [31:0]];
  int checks = 0, errors = 0;
  int cyc = 0, inflight = 0, max_inflight = 0, n_mreq = 0, n_mresp = 0, resp_delay = 0, stall = 0;
  logic toggle = 1'b0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic xreq(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [7:0] op,
                      input logic [31:0] exp, output int n);
    n = 0;
    xcel_reqstream_msg = xcel_req_t'{opaque: op, type_: w, addr: a, data: d};
    xcel_reqstream_val = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!xcel_reqstream_rdy && n < 1000);
    check("xreq_accept", 64'(xcel_reqstream_rdy), 1);
    if (xcel_reqstream_rdy) exp_q.push_back(xcel_resp_t'{opaque: op, type_: w, data: exp});
    @(posedge clk);
    #1;
    xcel_reqstream_val = 1'b0;
    xcel_reqstream_msg = '0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [7:0] op);
    int n;
    xreq(1'b1, a, d, op, 32'd0, n);
  endtask
  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("xresp_drained", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    xcel_respstream_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      xcel_respstream_rdy = toggle ? !xcel_respstream_rdy : 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (!reset && xcel_respstream_val && xcel_respstream_rdy) begin
      check("xresp_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("xresp", 64'(xcel_respstream_msg), 64'(exp_q.pop_front()));
    end
    if (!reset && xcel_reqstream_val && xcel_respstream_val && !xcel_respstream_rdy)
      check("req_blocked_when_full", 64'(xcel_reqstream_rdy), 0);
  end
  initial begin
    mem_reqstream_rdy = 1'b1;
    mem_respstream_val = 1'b0;
    mem_respstream_msg = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_q.delete();
        inflight = 0;
      end else begin
        if (mem_respstream_val && mem_respstream_rdy) begin
          void'(pend_q.pop_front());
          inflight--;
          n_mresp++;
        end
        if (mem_reqstream_val && mem_reqstream_rdy) begin
          logic [31:0] a;
          a = mem_reqstream_msg.addr;
          n_mreq++;
          inflight++;
          if (inflight > max_inflight) max_inflight = inflight;
          check("mreq_inflight_le_max", 64'(inflight <= P), 1);
          check("mreq_fields", {mem_reqstream_msg.type_, mem_reqstream_msg.opaque, mem_reqstream_msg.len,
                mem_reqstream_msg.data}, 0);
          check("mreq_expected", 64'(exp_addr.size() != 0), 1);
          if (exp_addr.size() != 0) check("mreq_addr", a, exp_addr.pop_front());
          pend_q.push_back('{data: mem.exists(a) ? mem[a] : 32'hdeadbeef, due: cyc + 1 + resp_delay});
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stall > 0) stall--;
      mem_reqstream_rdy = stall == 0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        mem_respstream_val = 1'b1;
        mem_respstream_msg = mem_resp_4B_t'{type_: VC_MEM_RESP_MSG_TYPE_READ, opaque: 8'd0, test: 2'd0,
                             len: 2'd0, data: pend_q[0].data};
      end else begin
        mem_respstream_val = 1'b0;
        mem_respstream_msg = '0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    int n, m0, r0, k;
    xcel_reqstream_val = 1'b0;
    xcel_reqstream_msg = '0;
    for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(4 * i)] = 32'(i + 1);
    mem[32'h2100] = 32'hFFFF_FFFF;
    mem[32'h2104] = 32'h0000_0002;
    for (int i = 0; i < 16; i++) mem[32'h3000 + 32'(4 * i)] = 32'(3 * i + 1);
    for (int i = 0; i < 8; i++) mem[32'h4000 + 32'(4 * i)] = 32'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_xresp_val", 64'(xcel_respstream_val), 0);
    check("rst_mreq_val", 64'(mem_reqstream_val), 0);
    check("rst_mresp_rdy", 64'(mem_respstream_rdy), 0);
    check("rst_xreq_rdy", 64'(xcel_reqstream_rdy), 1);
    @(posedge clk);
    #1;
    wr(XR_BASE, 32'h2000, 8'h01);
    wr(XR_SIZE, 32'd4, 8'h02);
    exp_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h200c};
    wr(XR_GO, 32'h0, 8'h03);
    xreq(1'b0, XR_GO, 32'h0, 8'h04, 32'd10, n);
    drain();
    check("sum4_all_issued", 64'(exp_addr.size()), 0);
    m0 = n_mreq;
    wr(XR_SIZE, 32'd0, 8'h05);
    wr(XR_GO, 32'h1234, 8'h06);
    xreq(1'b0, XR_GO, 32'h0, 8'h07, 32'd0, n);
    check("zero_len_calc_one_cycle", 64'(n), 2);
    drain();
    check("zero_len_no_mreq", 64'(n_mreq - m0), 0);
    wr(XR_BASE, 32'h2100, 8'h08);
    wr(XR_SIZE, 32'd2, 8'h09);
    exp_addr = '{32'h2100, 32'h2104};
    wr(XR_GO, 32'h0, 8'h0a);
    xreq(1'b0, XR_GO, 32'h0, 8'h0b, 32'h0000_0001, n);
    drain();
    wr(XR_BASE, 32'h3000, 8'h0c);
    wr(XR_SIZE, 32'd16, 8'h0d);
    for (int i = 0; i < 16; i++) exp_addr.push_back(32'h3000 + 32'(4 * i));
    resp_delay = 3;
    max_inflight = 0;
    stall = 5;
    wr(XR_GO, 32'h0, 8'h0e);
    xreq(1'b0, XR_GO, 32'h0, 8'h0f, 32'd376, n);
    drain();
    check("bp_max_inflight", 64'(max_inflight), 4);
    check("bp_all_issued", 64'(exp_addr.size()), 0);
    resp_delay = 0;
    wr(XR_BASE, 32'h2000, 8'h10);
    toggle = 1'b1;
    wr(5'd7, 32'h55, 8'h11);
    xreq(1'b0, XR_BASE, 32'h0, 8'h12, 32'h2000, n);
    xreq(1'b0, XR_SIZE, 32'h0, 8'h13, 32'd16, n);
    xreq(1'b0, 5'd7, 32'h0, 8'h14, 32'd0, n);
    drain();
    toggle = 1'b0;
    wr(XR_BASE, 32'h4000, 8'h15);
    wr(XR_SIZE, 32'd8, 8'h16);
    for (int i = 0; i < 8; i++) exp_addr.push_back(32'h4000 + 32'(4 * i));
    r0 = n_mresp;
    wr(XR_GO, 32'h0, 8'h17);
    k = 0;
    while (n_mresp - r0 < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_calc_progress", 64'(n_mresp - r0 >= 2), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_addr.delete();
    @(negedge clk);
    check("midrst_xreq_rdy", 64'(xcel_reqstream_rdy), 1);
    check("midrst_mreq_val", 64'(mem_reqstream_val), 0);
    check("midrst_mresp_rdy", 64'(mem_respstream_rdy), 0);
    check("midrst_xresp_val", 64'(xcel_respstream_val), 0);
    @(posedge clk);
    #1;
    xreq(1'b0, XR_GO, 32'h0, 8'h18, 32'd0, n);
    xreq(1'b0, XR_BASE, 32'h0, 8'h19, 32'd0, n);
    xreq(1'b0, XR_SIZE, 32'h0, 8'h1a, 32'd0, n);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
